// File: rtl/bcd_convert_seq_if.sv
// Handshake and result bundle between a requester and the sequential
// binary-to-BCD converter.
interface bcd_convert_seq_if #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
);
  logic                start;
  logic [WIDTH-1:0]    value;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] digits;
  logic                negative;
  logic                overflow;

  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  digits,
    input  negative,
    input  overflow
  );

  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output digits,
    output negative,
    output overflow
  );
endinterface

// File: rtl/bcd_convert_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// with sign handling, overflow detection and optional leading-zero blanking.
module bcd_convert_seq #(
  parameter int WIDTH    = 16,
  parameter int DIGITS   = 5,
  parameter bit SIGNED   = 1'b1,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  bcd_convert_seq_if.slave bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t             state_reg;
  logic [WIDTH-1:0]   mag_reg;
  logic [BCD_W-1:0]   bcd_reg;
  logic               ovf_reg;
  logic               neg_reg;
  logic [CNT_W-1:0]   cnt_reg;

  logic               busy_reg;
  logic               done_reg;
  logic [BCD_W-1:0]   digits_reg;
  logic               negative_reg;
  logic               overflow_reg;

  logic               sign_in;
  logic [WIDTH-1:0]   mag_in;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   bcd_blank;
  // upper_zero[i]: digit i and every digit above it are zero
  logic [DIGITS:1]    upper_zero;

  assign sign_in = SIGNED && bus.value[WIDTH-1];
  // Negating the most negative value wraps to 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign mag_in  = sign_in ? (~bus.value + WIDTH'(1)) : bus.value;

  assign upper_zero[DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] cur;
      assign cur = bcd_reg[gi*4 +: 4];
      assign bcd_adj[gi*4 +: 4] = (cur >= 4'd5) ? (cur + 4'd3) : cur;

      if (gi == 0) begin : g_ones
        assign bcd_blank[3:0] = cur;
      end else begin : g_upper
        assign upper_zero[gi] = (cur == 4'd0) && upper_zero[gi+1];
        assign bcd_blank[gi*4 +: 4] = (BLANK_LZ && upper_zero[gi]) ? 4'hF : cur;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      mag_reg      <= '0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
      neg_reg      <= 1'b0;
      cnt_reg      <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      digits_reg   <= '0;
      negative_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            mag_reg   <= mag_in;
            neg_reg   <= sign_in;
            bcd_reg   <= '0;
            ovf_reg   <= 1'b0;
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          // A carry out of the top digit means the value needs more digits
          // than we have; the low digits stay correct modulo 10^DIGITS.
          bcd_reg <= {bcd_adj[BCD_W-2:0], mag_reg[WIDTH-1]};
          mag_reg <= {mag_reg[WIDTH-2:0], 1'b0};
          ovf_reg <= ovf_reg | bcd_adj[BCD_W-1];
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_reg <= ST_DONE;
          end
        end

        ST_DONE: begin
          digits_reg   <= bcd_blank;
          negative_reg <= neg_reg;
          overflow_reg <= ovf_reg;
          done_reg     <= 1'b1;
          busy_reg     <= 1'b0;
          state_reg    <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;
  assign bus.digits   = digits_reg;
  assign bus.negative = negative_reg;
  assign bus.overflow = overflow_reg;

endmodule
